key_input_encoder: RTL
======================

Name: key_input_encoder

Overview:
Upstream input stage for the calculator datapath. It synchronises and debounces the 12 push switches, validates that exactly one switch is pressed, and encodes the press into a 4-bit key code. Each key code is delivered exactly once per physical press over a valid/ready handshake. The calculator core and LCD formatter consume `key_valid`/`key_code` directly, so they no longer need their own one-shot or switch-decode logic.

Parameters:
- `TICK_DIV`, default 5: clk cycles per debounce sample tick; allowed range is 2 and up.
- `DEBOUNCE_TICKS`, default 4: consecutive identical sample ticks required to accept a press, and also to accept a release; allowed range is 2 to 15.

Ports:
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst`  in  1  reset, asynchronous and active-low (0 = reset).
- `sw`  in  12  raw push switches, asynchronous, 1 = pressed.
- `key_ready`  in  1  consumer accepts the current key.
- `key_valid`  out  1  a key is pending.
- `key_code`  out  4  encoded key, held stable while `key_valid` is 1.
- `key_is_digit`  out  1  1 when `key_code` is in the range 0..9.
- `busy`  out  1  FSM is not in IDLE.
- `overrun`  out  1  one-clk pulse: a press was accepted while the previous key was still unconsumed, and the new press was dropped.
- `multi_err`  out  1  one-clk pulse: a debounced pattern had more than one switch set.

Behaviour:
- Reset (`rst`=0, async): all outputs 0; both synchroniser stages 0; tick divider 0; stability counter 0; snapshot 0; FSM in IDLE.
- Synchroniser: 2-flop (`s1 <= sw`; `s2 <= s1`). Only `s2` is used downstream.
- Tick divider: counts 0..`TICK_DIV`-1 and wraps. `tick`=1 in the cycle the count equals `TICK_DIV`-1. All FSM decisions happen only on tick cycles.
- Key map (one-hot `sw` to code):
  - `sw[11]`→0, `sw[10]`→1, `sw[9]`→2, `sw[8]`→3, `sw[7]`→4, `sw[6]`→5, `sw[5]`→6, `sw[4]`→7, `sw[3]`→8, `sw[2]`→9.
  - `sw[1]`→4'hA (clear), `sw[0]`→4'hB (enter/operator).
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
  - IDLE:
    - tick and `s2`≠0 → snapshot<=`s2`, cnt<=1, go to DEBOUNCE.
  - DEBOUNCE:
    - tick and `s2`≠snapshot → go to IDLE, cnt<=0. No event is produced.
    - tick and `s2`==snapshot and cnt+1<`DEBOUNCE_TICKS` → cnt++.
    - tick and `s2`==snapshot and cnt+1==`DEBOUNCE_TICKS` → accept, cnt<=0, go to HELD.
  - Accept actions:
    - snapshot not one-hot: pulse `multi_err`; no key is produced.
    - snapshot one-hot and (`key_valid`=0 or `key_ready`=1): load `key_code` and `key_is_digit`; `key_valid`<=1.
    - snapshot one-hot and `key_valid`=1 and `key_ready`=0: pulse `overrun`; the pending key is kept unchanged.
  - HELD:
    - tick and `s2`==0 → cnt<=1, go to RELEASE.
    - Any other value (including a change of pressed switch) is ignored. There is no auto-repeat.
  - RELEASE:
    - tick and `s2`≠0 → cnt<=0, go to HELD.
    - tick and `s2`==0 → cnt++. When cnt+1==`DEBOUNCE_TICKS`: cnt<=0, go to IDLE.
- Handshake:
  - `key_valid` clears on the clk edge where `key_valid`&`key_ready`=1.
  - If a consume and an accept happen in the same cycle, the new key is loaded and `key_valid` stays 1.
  - `key_ready` while `key_valid`=0 has no effect.
  - `key_code` and `key_is_digit` change only when a new key is loaded.
- Latency: `key_valid` rises on the clk edge of the accepting tick. With switches stable from cycle 0, that is at most 2 + `DEBOUNCE_TICKS`·`TICK_DIV` + `TICK_DIV` clk (≤27 clk at the defaults).
- `busy` = (state≠IDLE), registered together with the state.
- Reset asserted mid-press: everything returns to reset values immediately. After release of reset, a switch still held is treated as a new press and produces exactly one key.

Test Plan:
- Defaults; hold `sw`=12'h004 for 40 clk, `key_ready`=0 → `key_valid`=1 within 27 clk, `key_code`=9, `key_is_digit`=1. Exactly one key; `key_valid` stays 1 until `key_ready`.
- `sw`=12'h800 toggling 0/1 every 3 clk for 60 clk, then held steady → no key during the bounce. After the steady hold, exactly one key with `key_code`=0.
- `sw`=12'h300 held 40 clk → `multi_err` high for exactly 1 clk, `key_valid` stays 0. After release and then `sw`=12'h002 → `key_code`=4'hA, `key_is_digit`=0.
- Press 12'h400 and release, leave unconsumed, then press 12'h001 → `overrun` pulses once; `key_code` remains 1. Assert `key_ready` for 1 clk → `key_valid`=0.
- Hold 12'h010 for 200 clk with `key_ready`=1 → exactly one `key_valid` cycle, `key_code`=7. Release for 30 clk, press again → second key, `key_code`=7.
- Hold 12'h080; drive `rst`=0 for 3 clk while in HELD → all outputs 0 at once. Release reset with switch still held → one key, `key_code`=4.

Source files
------------

// File: rtl/key_input_encoder.sv
// rtl/key_input_encoder.sv - switch synchroniser, debouncer and one-shot key encoder
// Turns 12 raw push switches into one valid/ready key event per debounced press.
module key_input_encoder #(
    parameter int TICK_DIV       = 5,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] sw,
    input  logic        key_ready,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_is_digit,
    output logic        busy,
    output logic        overrun,
    output logic        multi_err
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    logic [11:0]      s1_q, s1_d, s2_q, s2_d, snap_q, snap_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_is_digit_q, key_is_digit_d;
    logic             busy_q, busy_d;
    logic             overrun_q, overrun_d;
    logic             multi_err_q, multi_err_d;

    logic             tick;
    logic             snap_onehot;
    logic [3:0]       snap_code;

    assign tick        = (div_q == DIV_LAST);
    assign snap_onehot = (snap_q != 12'd0) && ((snap_q & (snap_q - 12'd1)) == 12'd0);

    // Switch index i maps to code 11-i: sw[11] is digit 0, sw[0] is enter.
    always_comb begin
        snap_code = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (snap_q[i]) snap_code = 4'(11 - i);
        end
    end

    always_comb begin
        s1_d           = sw;
        s2_d           = s1_q;
        div_d          = tick ? '0 : div_q + 1'b1;
        state_d        = state_q;
        cnt_d          = cnt_q;
        snap_d         = snap_q;
        key_valid_d    = key_valid_q & ~key_ready;
        key_code_d     = key_code_q;
        key_is_digit_d = key_is_digit_q;
        overrun_d      = 1'b0;
        multi_err_d    = 1'b0;

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (s2_q != 12'd0) begin
                        snap_d  = s2_q;
                        cnt_d   = 4'd1;
                        state_d = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (s2_q != snap_q) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = HELD;
                        if (!snap_onehot) begin
                            multi_err_d = 1'b1;
                        end else if (!key_valid_q || key_ready) begin
                            // A same-cycle consume frees the slot, so the new key wins.
                            key_valid_d    = 1'b1;
                            key_code_d     = snap_code;
                            key_is_digit_d = (snap_code < 4'd10);
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (s2_q == 12'd0) begin
                        cnt_d   = 4'd1;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (s2_q != 12'd0) begin
                        cnt_d   = 4'd0;
                        state_d = HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            div_q          <= '0;
            cnt_q          <= '0;
            snap_q         <= '0;
            state_q        <= IDLE;
            key_valid_q    <= 1'b0;
            key_code_q     <= '0;
            key_is_digit_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            multi_err_q    <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            div_q          <= div_d;
            cnt_q          <= cnt_d;
            snap_q         <= snap_d;
            state_q        <= state_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_is_digit_q <= key_is_digit_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            multi_err_q    <= multi_err_d;
        end
    end

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_is_digit = key_is_digit_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
    assign multi_err    = multi_err_q;
endmodule
